// File: rtl/decode_fwd_stage.sv
// decode_fwd_stage: Y86-64 decode/write-back stage with register file,
// five-source operand forwarding, load-use hazard detection and D->E register.
`default_nettype none

module decode_fwd_stage #(
  parameter int          DATA_W = 64,
  parameter int          NREG   = 15,
  parameter logic [3:0]  RSP_ID = 4'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic              ld_use_hazard,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [DATA_W-1:0] E_valC,
  output logic [1:0]        E_stat
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [1:0] S_AOK  = 2'd0;

  logic [DATA_W-1:0] regs [0:NREG-1];
  logic [3:0]        d_dstE;
  logic [3:0]        d_dstM;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] opnd_a;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
      4'h9, 4'hB:             d_srcA = RSP_ID;
      default:                d_srcA = RNONE;
    endcase
    case (D_icode)
      4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP_ID;
      default:                d_srcB = RNONE;
    endcase
    case (D_icode)
      4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP_ID;
      default:                d_dstE = RNONE;
    endcase
    case (D_icode)
      4'h5, 4'hB:             d_dstM = D_rA;
      default:                d_dstM = RNONE;
    endcase
  end

  // IDs outside the implemented register range read as zero
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (int'(d_srcA) < NREG) rf_a = regs[d_srcA];
    if (int'(d_srcB) < NREG) rf_b = regs[d_srcB];
  end

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [3:0]        s,
                                                input logic [DATA_W-1:0] rf);
    if (s == RNONE)        return '0;
    else if (s == e_dstE)  return e_valE;
    else if (s == M_dstM)  return m_valM;
    else if (s == M_dstE)  return M_valE;
    else if (s == W_dstM)  return W_valM;
    else if (s == W_dstE)  return W_valE;
    else                   return rf;
  endfunction

  always_comb begin
    fwd_a  = fwd_sel(d_srcA, rf_a);
    fwd_b  = fwd_sel(d_srcB, rf_b);
    opnd_a = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : fwd_a;
  end

  always_comb begin
    ld_use_hazard = (E_icode == 4'h5 || E_icode == 4'hB) && (E_dstM != RNONE) &&
                    (E_dstM == d_srcA || E_dstM == d_srcB);
  end

  // The M port is written second so it wins when both ports target one register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (W_dstE != RNONE && int'(W_dstE) < NREG) regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE && int'(W_dstM) < NREG) regs[W_dstM] <= W_valM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (E_stall) begin
      E_stat  <= E_stat;
    end else if (E_bubble) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valA  <= opnd_a;
      E_valB  <= fwd_b;
      E_valC  <= D_valC;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_fwd_stage.sv
// tb_decode_fwd_stage: directed bench for decode_fwd_stage with a behavioural
// reference model compared every negative clock edge.
`default_nettype none

module tb_decode_fwd_stage;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    D_stat;
  logic [3:0]    D_icode, D_ifun, D_rA, D_rB;
  logic [DW-1:0] D_valC, D_valP;
  logic [3:0]    e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [DW-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic          E_stall, E_bubble;
  logic [3:0]    d_srcA, d_srcB;
  logic          ld_use_hazard;
  logic [3:0]    E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [DW-1:0] E_valA, E_valB, E_valC;
  logic [1:0]    E_stat;

  int vectors = 0;
  int errors  = 0;

  decode_fwd_stage #(.DATA_W(DW), .NREG(15), .RSP_ID(4'd4)) dut (
    .clk(clk), .reset(reset),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .ld_use_hazard(ld_use_hazard),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valA(E_valA), .E_valB(E_valB),
    .E_valC(E_valC), .E_stat(E_stat)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] mrf [16];
  logic          model_ok = 1'b0;
  logic [1:0]    x_stat;
  logic [3:0]    x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [DW-1:0] x_valA, x_valB, x_valC;

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB})             return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6})       return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  // Forward sources listed newest-first; the first tag match supplies the value
  function automatic logic [DW-1:0] m_fwd(input logic [3:0] s);
    logic [3:0]    tags [5];
    logic [DW-1:0] vals [5];
    if (s == 4'hF) return '0;
    tags = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int k = 0; k < 5; k++)
      if (tags[k] == s) return vals[k];
    return mrf[s];
  endfunction

  task automatic m_nop();
    x_stat = 2'd0; x_icode = 4'h1; x_ifun = 4'h0;
    x_valA = '0; x_valB = '0; x_valC = '0;
    x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_nop();
      for (int i = 0; i < 16; i++) mrf[i] = '0;
      model_ok = 1'b1;
    end else begin
      if (!E_stall) begin
        if (E_bubble) m_nop();
        else begin
          x_stat  = D_stat;  x_icode = D_icode; x_ifun = D_ifun; x_valC = D_valC;
          x_srcA  = m_srcA(D_icode, D_rA);
          x_srcB  = m_srcB(D_icode, D_rB);
          x_dstE  = m_dstE(D_icode, D_rB);
          x_dstM  = m_dstM(D_icode, D_rA);
          x_valA  = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_fwd(x_srcA);
          x_valB  = m_fwd(x_srcB);
        end
      end
      if (W_dstE != 4'hF) mrf[W_dstE] = W_valE;
      if (W_dstM != 4'hF) mrf[W_dstM] = W_valM;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("E_stat",  DW'(E_stat),  DW'(x_stat));
      chk("E_icode", DW'(E_icode), DW'(x_icode));
      chk("E_ifun",  DW'(E_ifun),  DW'(x_ifun));
      chk("E_dstE",  DW'(E_dstE),  DW'(x_dstE));
      chk("E_dstM",  DW'(E_dstM),  DW'(x_dstM));
      chk("E_srcA",  DW'(E_srcA),  DW'(x_srcA));
      chk("E_srcB",  DW'(E_srcB),  DW'(x_srcB));
      chk("E_valA",  E_valA, x_valA);
      chk("E_valB",  E_valB, x_valB);
      chk("E_valC",  E_valC, x_valC);
      chk("d_srcA",  DW'(d_srcA), DW'(m_srcA(D_icode, D_rA)));
      chk("d_srcB",  DW'(d_srcB), DW'(m_srcB(D_icode, D_rB)));
      chk("hazard",  DW'(ld_use_hazard),
          DW'((x_icode inside {4'h5, 4'hB}) && x_dstM != 4'hF &&
              (x_dstM == m_srcA(D_icode, D_rA) || x_dstM == m_srcB(D_icode, D_rB))));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    D_stat = 2'd0; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
    e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;
    E_stall = 1'b0; E_bubble = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_icode", DW'(E_icode), DW'(4'h1));
    chk("rst_dstE",  DW'(E_dstE),  DW'(4'hF));
    chk("rst_valA",  E_valA, '0);

    // register-file read of a value written by W the cycle before
    W_dstE = 4'd3; W_valE = 64'h55;
    tick();
    idle(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'hF;
    tick();
    chk("rf_read_valA", E_valA, 64'h55);

    // forwarding priority: e beats M beats W
    idle(); D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'hF;
    e_dstE = 4'd2; e_valE = 64'h11; M_dstE = 4'd2; M_valE = 64'h22;
    W_dstE = 4'd2; W_valE = 64'h33;
    tick();
    chk("fwd_e", E_valA, 64'h11);
    e_dstE = 4'hF;
    tick();
    chk("fwd_M", E_valA, 64'h22);

    // load-use hazard
    idle(); D_icode = 4'h5; D_rA = 4'd1; D_rB = 4'hF;
    tick();
    D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'hF;
    #1 chk("hazard_hit", DW'(ld_use_hazard), DW'(1'b1));
    D_rA = 4'd7; D_rB = 4'd2;
    #1 chk("hazard_miss", DW'(ld_use_hazard), DW'(1'b0));

    // call: valP into A, stack pointer into B
    idle(); W_dstE = 4'd4; W_valE = 64'h100;
    tick();
    idle(); D_icode = 4'h8; D_valP = 64'h40; D_valC = 64'h1234;
    tick();
    chk("call_valA", E_valA, 64'h40);
    chk("call_valB", E_valB, 64'h100);
    chk("call_dstE", DW'(E_dstE), DW'(4'd4));
    chk("call_srcA", DW'(E_srcA), DW'(4'hF));

    // stall dominates bubble; bubble alone injects a NOP; RF writes still land
    idle(); D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd2; E_stall = 1'b1; E_bubble = 1'b1;
    tick();
    chk("stall_icode", DW'(E_icode), DW'(4'h8));
    chk("stall_valA",  E_valA, 64'h40);
    E_stall = 1'b0;
    W_dstM = 4'd4; W_valM = 64'h77; W_dstE = 4'd4; W_valE = 64'h99;
    tick();
    chk("bubble_icode", DW'(E_icode), DW'(4'h1));
    chk("bubble_dstE",  DW'(E_dstE),  DW'(4'hF));
    idle(); D_icode = 4'h9;
    tick();
    chk("rsp_valA", E_valA, 64'h77);
    chk("rsp_valB", E_valB, 64'h77);

    // asynchronous reset with an OPq pending in E
    idle(); D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd3; D_stat = 2'd2;
    tick();
    chk("pre_rst_icode", DW'(E_icode), DW'(4'h6));
    #2 reset = 1'b1;
    #1 chk("async_icode", DW'(E_icode), DW'(4'h1));
    chk("async_dstE", DW'(E_dstE), DW'(4'hF));
    tick();
    reset = 1'b0;
    idle(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'hF;
    tick();
    chk("post_rst_rf", E_valA, '0);

    idle();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_fwd_stage.md
Name: decode_fwd_stage

Overview:
- Parametrised Y86-64 decode/write-back stage: register file, source/destination select, 5-source forwarding priority chain, load-use hazard flag, and D->E pipeline register.
- Sits between fetch (D_* pipeline register) and execute.
- Improves on the plain decode stage: configurable data width and register count, E-stage stall as well as bubble, register-file reset, and a load-use hazard output.

Parameters:
- DATA_W, 64, width of register values, valC, valP.
- NREG, 15, number of architectural registers (1..15). IDs >= NREG other than 4'hF read 0 and are never written.
- RSP_ID, 4, register ID used as the stack pointer.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- D_stat  in  2  fetch status.
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decoded instruction fields.
- D_valC, D_valP  in  DATA_W  constant and next PC.
- e_dstE  in  4  with e_valE  in  DATA_W  execute ALU forward.
- M_dstM  in  4  with m_valM  in  DATA_W  memory-read forward.
- M_dstE  in  4  with M_valE  in  DATA_W  memory-stage ALU forward.
- W_dstM  in  4  with W_valM  in  DATA_W  write-back load forward and register-file write.
- W_dstE  in  4  with W_valE  in  DATA_W  write-back ALU forward and register-file write.
- E_stall  in  1  hold E register.
- E_bubble  in  1  inject NOP into E.
- d_srcA, d_srcB  out  4  combinational source IDs.
- ld_use_hazard  out  1  combinational load-use hazard flag.
- E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered.
- E_valA, E_valB, E_valC  out  DATA_W  registered.
- E_stat  out  2  registered.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - E_icode=1 (NOP), E_ifun=0, E_stat=0 (AOK).
  - E_valA=E_valB=E_valC=0.
  - E_dstE=E_dstM=E_srcA=E_srcB=4'hF.
  - All registers in the register file = 0.
- d_srcA:
  - rA for icode 2, 4, 6, A.
  - RSP_ID for 9, B.
  - Otherwise F.
- d_srcB:
  - rB for 4, 5, 6.
  - RSP_ID for 8, 9, A, B.
  - Otherwise F.
- d_dstE:
  - rB for 2, 3, 6.
  - RSP_ID for 8, 9, A, B.
  - Otherwise F.
- d_dstM:
  - rA for 5, B.
  - Otherwise F.
- Operand A:
  - valP for icode 7 or 8.
  - Otherwise forward(d_srcA).
- Operand B: forward(d_srcB).
- forward(s), first match wins:
  1. s==F -> 0.
  2. s==e_dstE -> e_valE.
  3. s==M_dstM -> m_valM.
  4. s==M_dstE -> M_valE.
  5. s==W_dstM -> W_valM.
  6. s==W_dstE -> W_valE.
  7. Otherwise register-file read.
  - A register-file read never sees the same-cycle write; the W forward rules cover that case.
- Register-file write at posedge clk:
  - W_dstE != F writes W_valE; W_dstM != F writes W_valM.
  - If both target the same register, W_valM wins.
  - Writes occur regardless of E_stall/E_bubble.
- ld_use_hazard = (E_icode==5 or E_icode==B) and E_dstM != F and (E_dstM==d_srcA or E_dstM==d_srcB).
- E register update at posedge, priority order:
  1. E_stall: hold all E_* outputs.
  2. E_bubble: load the reset values (NOP, dst/src = F, stat AOK).
  3. Otherwise: load D_stat, D_icode, D_ifun, operand A, operand B, D_valC, d_dstE, d_dstM, d_srcA, d_srcB.
- Latency: one cycle from D_* inputs to E_*.
- Widths: all value paths are DATA_W with no truncation or extension. Register IDs are fixed at 4 bits.

Test Plan:
- Reset mid-run with E_icode=6 pending -> E_icode=1 and E_dstE=F immediately, without waiting for a clock edge. After the next clock, a read of any register with no forward match returns 0.
- W_dstE=3, W_valE=0x55 on cycle N; cycle N+1 D_icode=6, D_rA=3, D_rB=F -> E_valA=0x55 after the edge (value read from the register file).
- D_icode=6, D_rA=2, with e_dstE=2/e_valE=0x11, M_dstE=2/M_valE=0x22, W_dstE=2/W_valE=0x33 all asserted -> E_valA=0x11. Remove the e_ forward -> E_valA=0x22.
- E_icode=5, E_dstM=1 registered; D_icode=6, D_rA=1 -> ld_use_hazard=1. Same setup with D_rA=7, D_rB=2 -> 0.
- D_icode=8, D_valP=0x40, RSP holds 0x100 -> E_valA=0x40, E_valB=0x100, E_dstE=4, E_srcA=F.
- E_stall=1 with E_bubble=1 -> E outputs unchanged. E_stall=0 with E_bubble=1 -> E_icode=1, E_dstE=F. Register write on W_dstM=4, W_valM=0x77 still lands, and with W_dstE=4 in the same cycle, W_valM wins (RSP=0x77).
